// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next fetch address selection: flush target, taken branch target, or sequential PC.
module pc_next_sel #(
  parameter int unsigned XLEN = fetch_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_sel_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    next_pc_o  = pc_i + XLEN'(4);
    misalign_o = 1'b0;
    if (flush_i) begin
      next_pc_o = {flush_pc_i[XLEN-1:2], 2'b00};
    end else if (pc_sel_i) begin
      next_pc_o  = {alu_data_i[XLEN-1:2], 2'b00};
      misalign_o = (alu_data_i[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory request, holds the fetched word until decode retires it.
module instr_fetch_unit #(
  parameter int unsigned     XLEN         = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pc_sel,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_four,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic            o_misalign
);

  import fetch_pkg::*;

  state_e          state_q, state_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] next_pc;
  logic            next_misalign;

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc_i       (pc_q),
    .pc_sel_i   (i_pc_sel),
    .alu_data_i (i_alu_data),
    .flush_i    (i_flush),
    .flush_pc_i (i_flush_pc),
    .next_pc_o  (next_pc),
    .misalign_o (next_misalign)
  );

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;

    // Flush redirects the fetch address regardless of state; the FSM decides what to drop.
    if (i_flush) fetch_pc_d = next_pc;

    unique case (state_q)
      S_REQ: begin
        if (i_imem_gnt) begin
          state_d = S_WAIT;
          kill_d  = i_flush;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (kill_q || i_flush) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = i_imem_rdata;
            pc_d    = fetch_pc_q;
            state_d = S_HOLD;
          end
        end else if (i_flush) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_flush) begin
          state_d = S_REQ;
        end else if (i_instr_ready) begin
          fetch_pc_d = next_pc;
          misalign_d = next_misalign;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      state_q    <= S_REQ;
      kill_q     <= 1'b0;
      fetch_pc_q <= RESET_VECTOR;
      instr_q    <= XLEN'(NOP_INSTR);
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_imem_req    = (state_q == S_REQ) && !i_reset;
  assign o_imem_addr   = fetch_pc_q;
  assign o_instr       = instr_q;
  assign o_pc          = pc_q;
  assign o_pc_four     = pc_q + XLEN'(4);
  assign o_instr_valid = (state_q == S_HOLD);
  assign o_misalign    = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected {pc, instr} deliveries.
module tb_instr_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pc_sel = 1'b0;
  logic [31:0] i_alu_data = '0;
  logic        i_flush = 1'b0;
  logic [31:0] i_flush_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic        o_instr_valid;
  logic        i_instr_ready = 1'b0;
  logic        o_misalign;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_pc;   // bench's expected fetch address
  logic [31:0] last_pc;    // PC of the instruction currently held
  logic [31:0] hold_instr;

  instr_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pc_sel      (i_pc_sel),
    .i_alu_data    (i_alu_data),
    .i_flush       (i_flush),
    .i_flush_pc    (i_flush_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_pc_four     (o_pc_four),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_misalign    (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Starting in S_REQ: optionally stall the grant, then return data one cycle after grant.
  task automatic fetch(input int gnt_wait, input logic [31:0] data);
    check("req", 32'(o_imem_req), 32'd1);
    check("addr", o_imem_addr, model_pc);
    for (int i = 0; i < gnt_wait; i++) begin
      step();
      check("req_stall", 32'(o_imem_req), 32'd1);
      check("addr_stall", o_imem_addr, model_pc);
    end
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    check("wait_valid", 32'(o_instr_valid), 32'd0);
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = data;
    sb.push_back('{pc: model_pc, instr: data});
    step();
    i_imem_rvalid = 1'b0;
    check("valid", 32'(o_instr_valid), 32'd1);
    check("sb_nonempty", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("instr", o_instr, e.instr);
      check("pc", o_pc, e.pc);
      check("pc_four", o_pc_four, e.pc + 32'd4);
      last_pc = e.pc;
    end
  endtask

  task automatic retire(input logic sel, input logic [31:0] alu);
    i_instr_ready = 1'b1;
    i_pc_sel      = sel;
    i_alu_data    = alu;
    step();
    i_instr_ready = 1'b0;
    i_pc_sel      = 1'b0;
    i_alu_data    = 32'hA5A5_A5A5;
    model_pc = sel ? {alu[31:2], 2'b00} : last_pc + 32'd4;
    check("ret_valid", 32'(o_instr_valid), 32'd0);
    check("ret_req", 32'(o_imem_req), 32'd1);
    check("ret_addr", o_imem_addr, model_pc);
    check("ret_misalign", 32'(o_misalign), 32'(sel && (alu[1:0] != 2'b00)));
  endtask

  initial begin
    // Reset state.
    step();
    step();
    check("rst_req", 32'(o_imem_req), 32'd0);
    check("rst_valid", 32'(o_instr_valid), 32'd0);
    check("rst_instr", o_instr, 32'h0000_0013);
    check("rst_pc", o_pc, 32'h0);
    check("rst_pc_four", o_pc_four, 32'h4);
    check("rst_misalign", 32'(o_misalign), 32'd0);
    i_reset = 1'b0;
    model_pc = 32'h0;
    #1;
    fetch(0, 32'h0050_0093);

    // Sequential and taken retires.
    retire(1'b1, 32'h0000_0010);
    fetch(0, 32'h0000_1111);
    retire(1'b0, 32'h0000_0000);
    check("seq_addr_14", o_imem_addr, 32'h14);
    fetch(0, 32'h0000_2222);
    retire(1'b1, 32'h0000_0040);
    fetch(0, 32'h0000_3333);

    // Misaligned target: aligned fetch, single-cycle pulse.
    retire(1'b1, 32'h0000_0046);
    check("mis_addr", o_imem_addr, 32'h44);
    step();
    check("mis_pulse_end", 32'(o_misalign), 32'd0);

    // Grant stalled 5 cycles, then decode stalls 4 cycles.
    fetch(5, 32'h0000_4444);
    hold_instr = o_instr;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_valid", 32'(o_instr_valid), 32'd1);
      check("hold_req", 32'(o_imem_req), 32'd0);
      check("hold_instr", o_instr, hold_instr);
      check("hold_pc", o_pc, last_pc);
    end

    // Flush in S_WAIT, stale response discarded.
    retire(1'b0, 32'h0);
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    i_flush = 1'b1;
    i_flush_pc = 32'h0000_0100;
    step();
    i_flush = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata = 32'hDEAD_BEEF;
    check("kill_wait_valid", 32'(o_instr_valid), 32'd0);
    step();
    i_imem_rvalid = 1'b0;
    model_pc = 32'h100;
    check("kill_valid", 32'(o_instr_valid), 32'd0);
    check("kill_req", 32'(o_imem_req), 32'd1);
    check("kill_addr", o_imem_addr, 32'h100);
    fetch(0, 32'h0000_5555);

    // Flush and taken retire in the same cycle: flush wins.
    i_flush = 1'b1;
    i_flush_pc = 32'h0000_0203;
    i_instr_ready = 1'b1;
    i_pc_sel = 1'b1;
    i_alu_data = 32'h0000_0082;
    step();
    i_flush = 1'b0;
    i_instr_ready = 1'b0;
    i_pc_sel = 1'b0;
    model_pc = 32'h200;
    check("fr_valid", 32'(o_instr_valid), 32'd0);
    check("fr_addr", o_imem_addr, 32'h200);
    check("fr_misalign", 32'(o_misalign), 32'd0);
    fetch(0, 32'h0000_6666);

    // Flush in S_REQ without grant.
    retire(1'b0, 32'h0);
    i_flush = 1'b1;
    i_flush_pc = 32'h0000_0300;
    step();
    i_flush = 1'b0;
    model_pc = 32'h300;
    check("reqflush_addr", o_imem_addr, 32'h300);
    fetch(0, 32'h0000_7777);

    // PC wraps modulo 2^32.
    retire(1'b1, 32'hFFFF_FFFC);
    fetch(0, 32'h0000_8888);
    retire(1'b0, 32'h0);
    check("wrap_addr", o_imem_addr, 32'h0);

    // Reset in S_WAIT; response after reset ignored.
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("mid_rst_valid", 32'(o_instr_valid), 32'd0);
    check("mid_rst_instr", o_instr, 32'h0000_0013);
    check("mid_rst_pc", o_pc, 32'h0);
    i_imem_rvalid = 1'b1;
    i_imem_rdata = 32'hBAD0_BAD0;
    step();
    i_imem_rvalid = 1'b0;
    model_pc = 32'h0;
    check("post_rst_valid", 32'(o_instr_valid), 32'd0);
    fetch(0, 32'h0000_9999);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the RISC-V core. Holds the architectural PC and issues one instruction-memory request at a time. It presents the returned instruction with its PC to decode. Each time decode retires an instruction, it takes the next-PC decision from the branch encoder (`i_pc_sel`) together with the ALU-computed target. An external flush (trap/exception path) can redirect fetch in any state.

## Interface
Parameters:
- `RESET_VECTOR`, default `32'h0000_0000`: first fetch address after reset.
- `XLEN`, default `32`: PC/data width.

Ports:
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: one clock; reset is synchronous and active-high.
- `i_pc_sel`, in, 1: branch/jump taken for the retiring instruction (from branch encoder).
- `i_alu_data`, in, XLEN: branch/jump target.
- `i_flush`, in, 1: redirect fetch to `i_flush_pc`.
- `i_flush_pc`, in, XLEN: flush target.
- `o_imem_req`, out, 1: fetch request valid.
- `o_imem_addr`, out, XLEN: fetch address.
- `i_imem_gnt`, in, 1: memory accepted request.
- `i_imem_rvalid`, in, 1: read data valid.
- `i_imem_rdata`, in, XLEN: instruction word.
- `o_instr`, out, XLEN: instruction to decode.
- `o_pc`, out, XLEN: PC of `o_instr`.
- `o_pc_four`, out, XLEN: `o_pc + 4`.
- `o_instr_valid`, out, 1: `o_instr`/`o_pc` valid.
- `i_instr_ready`, in, 1: decode retires the instruction this cycle.
- `o_misalign`, out, 1: one-cycle pulse on a redirect whose target has bits [1:0] != 0.

## Operation
- Internal register `fetch_pc` holds the next address to fetch. `o_imem_addr` = `fetch_pc`.
- States:
  - **S_REQ**: `o_imem_req`=1. On `i_imem_gnt` go to S_WAIT.
  - **S_WAIT**: wait for `i_imem_rvalid`. If `kill`=0, capture `i_imem_rdata` into `o_instr`, set `o_pc`=`fetch_pc`, go to S_HOLD. If `kill`=1, discard the data, clear `kill`, go to S_REQ.
  - **S_HOLD**: `o_instr_valid`=1. On `i_instr_ready` (retire):
    - `fetch_pc` ← `i_pc_sel` ? `{i_alu_data[XLEN-1:2],2'b00}` : `o_pc+4`.
    - Go to S_REQ.
- Exactly one outstanding fetch. Request and address stay stable until `i_imem_gnt`.
- `i_pc_sel` and `i_alu_data` are sampled only on retire. They are ignored otherwise.
- `o_misalign` pulses in the cycle after a taken retire with `i_alu_data[1:0]`!=0.
- PC arithmetic is modulo 2^XLEN: `32'hFFFF_FFFC + 4` = 0.
- Flush (highest priority, any state): `fetch_pc` ← `{i_flush_pc[XLEN-1:2],2'b00}`. Then, by state:
  - S_HOLD: drop valid, go to S_REQ. A concurrent `i_instr_ready` is ignored (no retire, no misalign pulse).
  - S_REQ without gnt: stay in S_REQ; the address updates the next cycle.
  - S_REQ with gnt the same cycle: go to S_WAIT with `kill`=1.
  - S_WAIT without rvalid: set `kill`=1.
  - S_WAIT with rvalid the same cycle: discard the data, go to S_REQ.

## Timing
- Reset values:
  - State S_REQ; `fetch_pc`=`RESET_VECTOR`; `kill`=0.
  - `o_imem_req`=0 while `i_reset`=1.
  - `o_instr`=`32'h0000_0013` (NOP); `o_pc`=`RESET_VECTOR`; `o_pc_four`=`RESET_VECTOR+4`.
  - `o_instr_valid`=0; `o_misalign`=0.
- First cycle after reset deasserts: `o_imem_req`=1, `o_imem_addr`=`RESET_VECTOR`.
- Memory contract: `i_imem_rvalid` arrives no earlier than the cycle after gnt. `i_imem_rvalid` outside S_WAIT is ignored.
- Latency: gnt in cycle N, rvalid in cycle M>N gives `o_instr_valid`=1 in cycle M+1.
- Retire in cycle K gives the next request in cycle K+1. Back-to-back throughput with single-cycle memory is one instruction per 3 cycles.
- `o_instr`, `o_pc`, `o_pc_four` hold while valid and not retired.
- Reset mid-operation wins over everything. An in-flight response after reset is ignored (state S_REQ).

## Structure
- Package `fetch_pkg`: state enum (`S_REQ`, `S_WAIT`, `S_HOLD`), `NOP_INSTR = 32'h0000_0013`, `XLEN`.
- One sub-module `pc_next_sel` (combinational): inputs `o_pc`, `i_pc_sel`, `i_alu_data`, `i_flush`, `i_flush_pc`. Outputs the next PC (aligned) and the misalign flag.
- FSM, `kill` flag and output registers live in the top module.

## Test plan
- Reset release, memory grants immediately, rvalid the next cycle with `32'h0050_0093` → req at `RESET_VECTOR`; `o_instr_valid` two cycles after gnt; `o_pc`=0, `o_pc_four`=4.
- Retire at PC `0x10` with `i_pc_sel`=0 → next `o_imem_addr`=`0x14`. Retire with `i_pc_sel`=1, `i_alu_data`=`0x40` → next `o_imem_addr`=`0x40`, `o_misalign`=0.
- Taken retire with `i_alu_data`=`0x46` → fetch `0x44`, `o_misalign` high for exactly one cycle.
- Flush to `0x100` while in S_WAIT; stale rvalid with `32'hDEAD_BEEF` → data discarded, `o_instr_valid` stays 0, next req addr `0x100`.
- `i_imem_gnt` held low 5 cycles → `o_imem_req`/`o_imem_addr` stable throughout. `i_instr_ready` low 4 cycles in S_HOLD → outputs stable, no new request.
- `i_flush` and `i_instr_ready` (with `i_pc_sel`=1) in the same cycle → flush target fetched, branch ignored. `i_reset` asserted in S_WAIT → next cycle `o_instr_valid`=0, `o_instr`=NOP, `o_pc`=`RESET_VECTOR`.
